// File: rtl/vga_timing_pkg.sv
// Shared constants and payload types for the SXGA timing generator.
// Default timing is 1280x1024@60 with a 108 MHz pixel clock.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 11;

  localparam int unsigned SXGA_H_VISIBLE = 1280;
  localparam int unsigned SXGA_H_FRONT   = 48;
  localparam int unsigned SXGA_H_SYNC    = 112;
  localparam int unsigned SXGA_H_BACK    = 248;
  localparam int unsigned SXGA_V_VISIBLE = 1024;
  localparam int unsigned SXGA_V_FRONT   = 1;
  localparam int unsigned SXGA_V_SYNC    = 3;
  localparam int unsigned SXGA_V_BACK    = 38;

  localparam int unsigned RGB_R_MSB = 7;
  localparam int unsigned RGB_R_LSB = 5;
  localparam int unsigned RGB_G_MSB = 4;
  localparam int unsigned RGB_G_LSB = 2;
  localparam int unsigned RGB_B_MSB = 1;
  localparam int unsigned RGB_B_LSB = 0;

  // RGB332 pixel as presented by the pixel source.
  typedef struct packed {
    logic [RGB_R_MSB-RGB_R_LSB:0] r;
    logic [RGB_G_MSB-RGB_G_LSB:0] g;
    logic [RGB_B_MSB-RGB_B_LSB:0] b;
  } rgb332_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus sync and visible decodes.
// The decodes are combinational on the registered count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned VISIBLE          = SXGA_H_VISIBLE,
  parameter int unsigned FRONT            = SXGA_H_FRONT,
  parameter int unsigned SYNC             = SXGA_H_SYNC,
  parameter int unsigned BACK             = SXGA_H_BACK,
  parameter bit          SYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic               FCLK,
  input  logic               RST_IN,
  input  logic               en,
  output logic [COORD_W-1:0] count,
  output logic               wrap,
  output logic               sync,
  output logic               active
);

  localparam int unsigned TOTAL      = VISIBLE + FRONT + SYNC + BACK;
  localparam int unsigned SYNC_START = VISIBLE + FRONT;
  localparam int unsigned SYNC_END   = SYNC_START + SYNC;

  logic [COORD_W-1:0] last_c;
  logic               at_end_c;
  logic               in_sync_c;
  logic [31:0]        count_u;

  assign last_c   = COORD_W'(TOTAL - 1);
  assign at_end_c = (count == last_c);
  assign count_u  = 32'(count);

  always_ff @(posedge FCLK or posedge RST_IN) begin
    if (RST_IN) begin
      count <= '0;
    end else if (en) begin
      count <= at_end_c ? '0 : count + COORD_W'(1);
    end
  end

  // Decodes are done at 32 bits so a sync ending exactly at 2048 still works.
  assign in_sync_c = (count_u >= SYNC_START) && (count_u < SYNC_END) && !RST_IN;
  assign wrap      = en && at_end_c;
  assign sync      = in_sync_c ? SYNC_ACTIVE_HIGH : !SYNC_ACTIVE_HIGH;
  assign active    = (count_u < VISIBLE) && !RST_IN;

endmodule

// File: rtl/vga_sxga_timing_top.sv
// SXGA VGA timing generator with pixel gating towards the DAC pins.
// A clock-enable divider stands in for a DCM-generated pixel clock.
module vga_sxga_timing_top
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE        = SXGA_H_VISIBLE,
  parameter int unsigned H_FRONT          = SXGA_H_FRONT,
  parameter int unsigned H_SYNC           = SXGA_H_SYNC,
  parameter int unsigned H_BACK           = SXGA_H_BACK,
  parameter int unsigned V_VISIBLE        = SXGA_V_VISIBLE,
  parameter int unsigned V_FRONT          = SXGA_V_FRONT,
  parameter int unsigned V_SYNC           = SXGA_V_SYNC,
  parameter int unsigned V_BACK           = SXGA_V_BACK,
  parameter bit          SYNC_ACTIVE_HIGH = 1'b1,
  parameter int unsigned CLK_DIV          = 1
) (
  input  logic               FCLK,
  input  logic               RST_IN,
  input  logic [7:0]         PIXEL_DATA,
  output logic               DISPLAY_EN,
  output logic [COORD_W-1:0] POS_X,
  output logic [COORD_W-1:0] POS_Y,
  output logic [2:0]         R,
  output logic [2:0]         G,
  output logic [1:0]         B,
  output logic               HSYNC,
  output logic               VSYNC
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic             h_wrap;
  logic             v_wrap_unused;
  logic             h_active;
  logic             v_active;
  rgb332_t          pix;

  assign tick = (div_q == DIV_W'(CLK_DIV - 1));

  // Pixel clock enable: one tick every CLK_DIV FCLK cycles.
  always_ff @(posedge FCLK or posedge RST_IN) begin
    if (RST_IN) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  vga_axis_counter #(
    .VISIBLE          (H_VISIBLE),
    .FRONT            (H_FRONT),
    .SYNC             (H_SYNC),
    .BACK             (H_BACK),
    .SYNC_ACTIVE_HIGH (SYNC_ACTIVE_HIGH)
  ) u_h (
    .FCLK   (FCLK),
    .RST_IN (RST_IN),
    .en     (tick),
    .count  (POS_X),
    .wrap   (h_wrap),
    .sync   (HSYNC),
    .active (h_active)
  );

  vga_axis_counter #(
    .VISIBLE          (V_VISIBLE),
    .FRONT            (V_FRONT),
    .SYNC             (V_SYNC),
    .BACK             (V_BACK),
    .SYNC_ACTIVE_HIGH (SYNC_ACTIVE_HIGH)
  ) u_v (
    .FCLK   (FCLK),
    .RST_IN (RST_IN),
    .en     (tick && h_wrap),
    .count  (POS_Y),
    .wrap   (v_wrap_unused),
    .sync   (VSYNC),
    .active (v_active)
  );

  assign DISPLAY_EN = h_active && v_active && !RST_IN;

  // Blank the DAC outside the visible area.
  assign pix = rgb332_t'(PIXEL_DATA);
  assign R   = DISPLAY_EN ? pix.r : 3'd0;
  assign G   = DISPLAY_EN ? pix.g : 3'd0;
  assign B   = DISPLAY_EN ? pix.b : 2'd0;

endmodule

// File: tb/tb_vga_sxga_timing_top.sv
// Randomised-pixel bench for vga_sxga_timing_top: three parameterisations
// checked every cycle against an arithmetic position model.
module tb_vga_sxga_timing_top;

  logic       FCLK = 1'b0;
  logic       rst  = 1'b1;
  logic [7:0] pix  = 8'hE5;
  logic       pix_fixed = 1'b1;
  logic [7:0] pix_val   = 8'hE5;
  longint     k;
  int         checks = 0;
  int         errors = 0;

  logic        de0, hs0, vs0, de1, hs1, vs1, de2, hs2, vs2;
  logic [10:0] x0, y0, x1, y1, x2, y2;
  logic [2:0]  r0, g0, r1, g1, r2, g2;
  logic [1:0]  b0, b1, b2;

  always #5 FCLK = ~FCLK;

  vga_sxga_timing_top u0 (
    .FCLK(FCLK), .RST_IN(rst), .PIXEL_DATA(pix), .DISPLAY_EN(de0),
    .POS_X(x0), .POS_Y(y0), .R(r0), .G(g0), .B(b0), .HSYNC(hs0), .VSYNC(vs0));

  vga_sxga_timing_top #(.SYNC_ACTIVE_HIGH(1'b0), .CLK_DIV(2)) u1 (
    .FCLK(FCLK), .RST_IN(rst), .PIXEL_DATA(pix), .DISPLAY_EN(de1),
    .POS_X(x1), .POS_Y(y1), .R(r1), .G(g1), .B(b1), .HSYNC(hs1), .VSYNC(vs1));

  vga_sxga_timing_top #(.H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(5),
                        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
                        .SYNC_ACTIVE_HIGH(1'b1), .CLK_DIV(3)) u2 (
    .FCLK(FCLK), .RST_IN(rst), .PIXEL_DATA(pix), .DISPLAY_EN(de2),
    .POS_X(x2), .POS_Y(y2), .R(r2), .G(g2), .B(b2), .HSYNC(hs2), .VSYNC(vs2));

  // FCLK edges seen since the last reset release.
  always @(posedge FCLK or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  always @(posedge FCLK) begin
    #1 pix = pix_fixed ? pix_val : 8'($urandom);
  end

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Position is simply elapsed pixels folded into line and frame lengths.
  task automatic check_inst(input string tag, input int d, hv, hf, hs, hb,
                            input int vv, vf, vs, vb, input bit pol,
                            input logic [10:0] ax, ay, input logic ade, ahs, avs,
                            input logic [2:0] ar, ag, input logic [1:0] ab);
    int ht, vt, x, y;
    longint p;
    bit de, hsa, vsa;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    if (rst) begin
      x = 0; y = 0; de = 0; hsa = 0; vsa = 0;
    end else begin
      p   = k / longint'(d);
      x   = int'(p % longint'(ht));
      y   = int'((p / longint'(ht)) % longint'(vt));
      de  = (x < hv) && (y < vv);
      hsa = (x >= hv + hf) && (x < hv + hf + hs);
      vsa = (y >= vv + vf) && (y < vv + vf + vs);
    end
    cmp({tag, ".pos_x"}, int'(ax), x);
    cmp({tag, ".pos_y"}, int'(ay), y);
    cmp({tag, ".display_en"}, int'(ade), int'(de));
    cmp({tag, ".hsync"}, int'(ahs), int'(hsa ? pol : !pol));
    cmp({tag, ".vsync"}, int'(avs), int'(vsa ? pol : !pol));
    cmp({tag, ".r"}, int'(ar), de ? int'(pix[7:5]) : 0);
    cmp({tag, ".g"}, int'(ag), de ? int'(pix[4:2]) : 0);
    cmp({tag, ".b"}, int'(ab), de ? int'(pix[1:0]) : 0);
  endtask

  always @(negedge FCLK) begin
    check_inst("u0", 1, 1280, 48, 112, 248, 1024, 1, 3, 38, 1'b1,
               x0, y0, de0, hs0, vs0, r0, g0, b0);
    check_inst("u1", 2, 1280, 48, 112, 248, 1024, 1, 3, 38, 1'b0,
               x1, y1, de1, hs1, vs1, r1, g1, b1);
    check_inst("u2", 3, 10, 2, 3, 5, 6, 1, 2, 3, 1'b1,
               x2, y2, de2, hs2, vs2, r2, g2, b2);
  end

  task automatic check_reset_literals(input string tag);
    cmp({tag, ".u0.pos"}, int'({x0, y0}), 0);
    cmp({tag, ".u0.de"}, int'(de0), 0);
    cmp({tag, ".u0.rgb"}, int'({r0, g0, b0}), 0);
    cmp({tag, ".u0.hsync"}, int'(hs0), 0);
    cmp({tag, ".u0.vsync"}, int'(vs0), 0);
    cmp({tag, ".u1.hsync"}, int'(hs1), 1);
    cmp({tag, ".u1.vsync"}, int'(vs1), 1);
    cmp({tag, ".u2.pos"}, int'({x2, y2}), 0);
  endtask

  task automatic release_reset();
    @(posedge FCLK);
    #1 rst = 1'b0;
  endtask

  initial begin
    int hs0_cnt, hs1_low, vs2_cnt, wait_cnt, gap, dly;
    bit found;
    hs0_cnt = 0; hs1_low = 0; vs2_cnt = 0;

    repeat (3) @(negedge FCLK);
    check_reset_literals("reset");
    release_reset();

    // Deterministic pass over one default line, one divided line and one small frame.
    for (int i = 0; i <= 3376; i++) begin
      @(negedge FCLK);
      if (i == 0) begin
        cmp("first.pos_x", int'(x0), 0);
        cmp("first.pos_y", int'(y0), 0);
        cmp("first.de", int'(de0), 1);
        cmp("first.r", int'(r0), 7);
        cmp("first.g", int'(g0), 1);
        cmp("first.b", int'(b0), 1);
        pix_val = 8'hFF;
      end
      if (i < 1688 && hs0) hs0_cnt++;
      if (i < 3376 && !hs1) hs1_low++;
      if (i < 720 && vs2) vs2_cnt++;
      if (i == 1279) cmp("line.de_at_1279", int'(de0), 1);
      if (i == 1280) cmp("line.de_at_1280", int'(de0), 0);
      if (i == 1300) cmp("gate.rgb_at_1300", int'({r0, g0, b0}), 0);
      if (i == 1000) cmp("gate.rgb_at_1000", int'({r0, g0, b0}), 255);
      if (i == 1687) cmp("wrap.before", int'({x0, y0}), int'({11'd1687, 11'd0}));
      if (i == 1688) cmp("wrap.after", int'({x0, y0}), int'({11'd0, 11'd1}));
      if (i == 3375) cmp("div2.before", int'({x1, y1}), int'({11'd1687, 11'd0}));
      if (i == 3376) cmp("div2.after", int'({x1, y1}), int'({11'd0, 11'd1}));
      if (i == 719) cmp("small.frame_end", int'({x2, y2}), int'({11'd19, 11'd11}));
      if (i == 720) cmp("small.frame_wrap", int'({x2, y2}), 0);
    end
    cmp("u0.hsync_cycles", hs0_cnt, 112);
    cmp("u1.hsync_low_cycles", hs1_low, 224);
    cmp("u2.vsync_cycles", vs2_cnt, 120);

    // Random pixels, then an asynchronous reset in the middle of a line.
    pix_fixed = 1'b0;
    repeat (1500) @(negedge FCLK);
    pix_fixed = 1'b1;
    found = 1'b0;
    wait_cnt = 0;
    while (!found && wait_cnt < 4000) begin
      @(negedge FCLK);
      wait_cnt++;
      if (x0 == 11'd500) found = 1'b1;
    end
    cmp("wait.pos_x_500", int'(found), 1);
    #2 rst = 1'b1;
    #1 check_reset_literals("async");
    repeat (3) @(negedge FCLK);
    release_reset();
    @(negedge FCLK);
    cmp("restart.pos", int'({x0, y0}), 0);
    cmp("restart.de", int'(de0), 1);

    // Random reset pulses at random phases with random pixels between them.
    pix_fixed = 1'b0;
    for (int n = 0; n < 3; n++) begin
      gap = int'($urandom_range(200, 2000));
      repeat (gap) @(negedge FCLK);
      @(posedge FCLK);
      dly = 1 + int'($urandom_range(0, 3));
      #(dly) rst = 1'b1;
      #1 check_reset_literals("pulse");
      repeat (int'($urandom_range(1, 4))) @(negedge FCLK);
      release_reset();
    end
    repeat (500) @(negedge FCLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
